// File: rtl/seu_npu_layer_seq_if.sv
// Descriptor read channel between the layer sequencer (master) and the DDR read controller (slave).
interface seu_npu_layer_seq_if #(
    parameter int unsigned DDR_AW = 32,
    parameter int unsigned DW     = 32
);
    logic              rd_req;
    logic [DDR_AW-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic              rd_ack;
    logic              rd_vld;
    logic [DW-1:0]     rd_data;

    modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_vld, rd_data);
    modport slave  (input rd_req, rd_addr, rd_len, output rd_ack, rd_vld, rd_data);
endinterface

// File: rtl/seu_npu_layer_seq.sv
// SEU_NPU layer sequencer: fetches per-layer descriptors, derives weight/BN/map addresses,
// launches each layer on the compute engine and waits for its completion.
module seu_npu_layer_seq #(
    parameter int unsigned DDR_AW     = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned DESC_WORDS = 4,
    parameter int unsigned LN_W       = 8
) (
    input  logic                         clk_trans,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [DDR_AW-1:0]            nn_wt_saddr,
    input  logic [DDR_AW-1:0]            nn_map0_saddr,
    input  logic [DDR_AW-1:0]            nn_map1_saddr,
    input  logic [DDR_AW-1:0]            nn_bn_saddr,
    input  logic [DDR_AW-1:0]            nn_layer_para_saddr,
    input  logic [DDR_AW-1:0]            nn_first_map_saddr,
    input  logic [LN_W-1:0]              nn_layers_num,
    seu_npu_layer_seq_if.master          rd,
    output logic                         layer_start,
    output logic [LN_W-1:0]              layer_idx,
    output logic [DDR_AW-1:0]            layer_wt_addr,
    output logic [DDR_AW-1:0]            layer_bn_addr,
    output logic [DDR_AW-1:0]            layer_in_addr,
    output logic [DDR_AW-1:0]            layer_out_addr,
    output logic [(DESC_WORDS-2)*DW-1:0] layer_cfg,
    input  logic                         layer_done,
    output logic                         busy,
    output logic                         nn_done
);
    localparam int unsigned CW = $clog2(DESC_WORDS);
    localparam logic [DDR_AW-1:0] STRIDE = DDR_AW'(DESC_WORDS * (DW / 8));

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RECV, S_ISSUE, S_WAIT, S_FIN} state_t;
    state_t state, state_nxt;

    logic [DDR_AW-1:0]            para_q, first_q, map0_q, map1_q, wt_acc, bn_acc;
    logic [LN_W-1:0]              layers_q, idx;
    logic [CW-1:0]                cnt;
    logic [DW-1:0]                words [DESC_WORDS];
    logic [(DESC_WORDS-2)*DW-1:0] cfg_nxt;
    logic                         last_beat, more_layers;

    assign last_beat   = (state == S_RECV) && rd.rd_vld && (cnt == CW'(DESC_WORDS - 1));
    assign more_layers = ({1'b0, idx} + (LN_W+1)'(1)) < {1'b0, layers_q};

    always_ff @(posedge clk_trans or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        rd.rd_req   = (state == S_REQ);
        rd.rd_addr  = para_q + DDR_AW'(idx) * STRIDE;
        rd.rd_len   = 8'(DESC_WORDS);
        layer_start = (state == S_ISSUE);
        busy        = (state != S_IDLE);
        nn_done     = (state == S_FIN);
        case (state)
            S_IDLE:  if (start && !abort) state_nxt = (nn_layers_num == '0) ? S_FIN : S_REQ;
            S_REQ:   if (rd.rd_ack) state_nxt = S_RECV;
            S_RECV:  if (last_beat) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (layer_done) state_nxt = more_layers ? S_REQ : S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // abort overrides every transition out of a busy state
        if (state != S_IDLE && abort) state_nxt = S_IDLE;
    end

    // The final beat is forwarded directly so layer_cfg is valid in the ISSUE cycle.
    always_comb begin
        cfg_nxt = '0;
        for (int unsigned i = 2; i < DESC_WORDS; i++)
            cfg_nxt[(i-2)*DW +: DW] = (i == DESC_WORDS - 1) ? rd.rd_data : words[CW'(i)];
    end

    always_ff @(posedge clk_trans or negedge rst_n) begin
        if (!rst_n) begin
            para_q         <= '0;
            first_q        <= '0;
            map0_q         <= '0;
            map1_q         <= '0;
            wt_acc         <= '0;
            bn_acc         <= '0;
            layers_q       <= '0;
            idx            <= '0;
            cnt            <= '0;
            for (int unsigned i = 0; i < DESC_WORDS; i++) words[i] <= '0;
            layer_idx      <= '0;
            layer_wt_addr  <= '0;
            layer_bn_addr  <= '0;
            layer_in_addr  <= '0;
            layer_out_addr <= '0;
            layer_cfg      <= '0;
        end else begin
            if (state == S_IDLE && start && !abort) begin
                para_q   <= nn_layer_para_saddr;
                first_q  <= nn_first_map_saddr;
                map0_q   <= nn_map0_saddr;
                map1_q   <= nn_map1_saddr;
                layers_q <= nn_layers_num;
                wt_acc   <= nn_wt_saddr;
                bn_acc   <= nn_bn_saddr;
                idx      <= '0;
            end
            if (state == S_REQ) cnt <= '0;
            if (state == S_RECV && rd.rd_vld && !abort) begin
                words[cnt] <= rd.rd_data;
                cnt        <= cnt + CW'(1);
            end
            if (state == S_RECV && state_nxt == S_ISSUE) begin
                layer_idx      <= idx;
                layer_wt_addr  <= wt_acc;
                layer_bn_addr  <= bn_acc;
                layer_in_addr  <= (idx == '0) ? first_q : layer_out_addr;
                layer_out_addr <= idx[0] ? map1_q : map0_q;
                layer_cfg      <= cfg_nxt;
            end
            if (state == S_WAIT && layer_done && !abort) begin
                wt_acc <= wt_acc + DDR_AW'(words[0]);
                bn_acc <= bn_acc + DDR_AW'(words[1]);
                idx    <= idx + LN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_seu_npu_layer_seq.sv
// Directed self-checking bench for seu_npu_layer_seq (DDR_AW=32, DW=32, DESC_WORDS=4, LN_W=8).
module tb_seu_npu_layer_seq;
    localparam logic [31:0] WT    = 32'h1000_0000;
    localparam logic [31:0] MAP0  = 32'h2000_0000;
    localparam logic [31:0] MAP1  = 32'h3000_0000;
    localparam logic [31:0] BN    = 32'h4000_0000;
    localparam logic [31:0] PARA  = 32'h5000_0000;
    localparam logic [31:0] FIRST = 32'h6000_0000;

    logic        clk_trans, rst_n, start, abort, layer_done;
    logic [31:0] nn_wt_saddr, nn_map0_saddr, nn_map1_saddr, nn_bn_saddr;
    logic [31:0] nn_layer_para_saddr, nn_first_map_saddr;
    logic [7:0]  nn_layers_num;
    logic        layer_start, busy, nn_done;
    logic [7:0]  layer_idx;
    logic [31:0] layer_wt_addr, layer_bn_addr, layer_in_addr, layer_out_addr;
    logic [63:0] layer_cfg;
    int          total, bad;

    seu_npu_layer_seq_if #(.DDR_AW(32), .DW(32)) rd_bus ();

    seu_npu_layer_seq #(.DDR_AW(32), .DW(32), .DESC_WORDS(4), .LN_W(8)) dut (
        .clk_trans(clk_trans), .rst_n(rst_n), .start(start), .abort(abort),
        .nn_wt_saddr(nn_wt_saddr), .nn_map0_saddr(nn_map0_saddr), .nn_map1_saddr(nn_map1_saddr),
        .nn_bn_saddr(nn_bn_saddr), .nn_layer_para_saddr(nn_layer_para_saddr),
        .nn_first_map_saddr(nn_first_map_saddr), .nn_layers_num(nn_layers_num),
        .rd(rd_bus),
        .layer_start(layer_start), .layer_idx(layer_idx), .layer_wt_addr(layer_wt_addr),
        .layer_bn_addr(layer_bn_addr), .layer_in_addr(layer_in_addr),
        .layer_out_addr(layer_out_addr), .layer_cfg(layer_cfg), .layer_done(layer_done),
        .busy(busy), .nn_done(nn_done)
    );

    initial begin
        clk_trans = 1'b0;
        forever #5 clk_trans = ~clk_trans;
    end

    task automatic tick();
        @(posedge clk_trans);
        #1;
    endtask

    task automatic set_bases(input logic [31:0] wt, input logic [7:0] n);
        nn_wt_saddr         = wt;
        nn_map0_saddr       = MAP0;
        nn_map1_saddr       = MAP1;
        nn_bn_saddr         = BN;
        nn_layer_para_saddr = PARA;
        nn_first_map_saddr  = FIRST;
        nn_layers_num       = n;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_done();
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
    endtask

    // One layer: descriptor fetch, ISSUE-cycle outputs, then parked in WAIT.
    task automatic do_layer(input logic [31:0] exp_rd, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3, input logic [7:0] exp_idx,
                            input logic [31:0] exp_wt, input logic [31:0] exp_bn,
                            input logic [31:0] exp_in, input logic [31:0] exp_out,
                            input int ack_dly, input bit slow, input bit noise);
        logic [31:0] w [4];
        int n;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        n = 0;
        while (rd_bus.rd_req !== 1'b1 && n < 50) begin tick(); n++; end
        total++;
        if (rd_bus.rd_req !== 1'b1) begin
            bad++; $display("FAIL rd_req_wait idx=%0d got=%b want=1", exp_idx, rd_bus.rd_req);
        end
        total++;
        if (rd_bus.rd_addr !== exp_rd || rd_bus.rd_len !== 8'd4) begin
            bad++; $display("FAIL rd_addr idx=%0d got=%h/%0d want=%h/4", exp_idx, rd_bus.rd_addr, rd_bus.rd_len, exp_rd);
        end
        for (int i = 0; i < ack_dly; i++) begin
            rd_bus.rd_vld  = slow;
            rd_bus.rd_data = 32'hDEAD_BEEF;
            tick();
            total++;
            if (rd_bus.rd_req !== 1'b1 || rd_bus.rd_addr !== exp_rd) begin
                bad++; $display("FAIL rd_addr_hold cyc=%0d got=%b/%h want=1/%h", i, rd_bus.rd_req, rd_bus.rd_addr, exp_rd);
            end
        end
        rd_bus.rd_vld = 1'b0;
        rd_bus.rd_ack = 1'b1;
        tick();
        rd_bus.rd_ack = 1'b0;
        total++;
        if (rd_bus.rd_req !== 1'b0) begin
            bad++; $display("FAIL rd_req_drop got=%b want=0", rd_bus.rd_req);
        end
        for (int k = 0; k < 4; k++) begin
            rd_bus.rd_vld  = 1'b1;
            rd_bus.rd_data = w[k];
            if (noise && k == 1) begin start = 1'b1; layer_done = 1'b1; end
            tick();
            rd_bus.rd_vld = 1'b0;
            start         = 1'b0;
            layer_done    = 1'b0;
            if (k < 3) begin
                total++;
                if (layer_start !== 1'b0) begin
                    bad++; $display("FAIL early_issue beat=%0d got=%b want=0", k, layer_start);
                end
                if (slow) tick();
            end
        end
        total++;
        if (layer_start !== 1'b1 || layer_idx !== exp_idx) begin
            bad++; $display("FAIL issue got=%b/%0d want=1/%0d", layer_start, layer_idx, exp_idx);
        end
        total++;
        if (layer_wt_addr !== exp_wt || layer_bn_addr !== exp_bn) begin
            bad++; $display("FAIL wt_bn idx=%0d got=%h/%h want=%h/%h", exp_idx, layer_wt_addr, layer_bn_addr, exp_wt, exp_bn);
        end
        total++;
        if (layer_in_addr !== exp_in || layer_out_addr !== exp_out) begin
            bad++; $display("FAIL in_out idx=%0d got=%h/%h want=%h/%h", exp_idx, layer_in_addr, layer_out_addr, exp_in, exp_out);
        end
        total++;
        if (layer_cfg !== {w3, w2}) begin
            bad++; $display("FAIL cfg idx=%0d got=%h want=%h", exp_idx, layer_cfg, {w3, w2});
        end
        if (noise) layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        total++;
        if (layer_start !== 1'b0) begin
            bad++; $display("FAIL issue_pulse got=%b want=0", layer_start);
        end
        tick();
        total++;
        if (rd_bus.rd_req !== 1'b0 || nn_done !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL wait_hold got=req%b done%b busy%b want=req0 done0 busy1", rd_bus.rd_req, nn_done, busy);
        end
    endtask

    task automatic check_finish(input string tag);
        total++;
        if (nn_done !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL %s_nn_done got=done%b busy%b want=done1 busy1", tag, nn_done, busy);
        end
        tick();
        total++;
        if (nn_done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL %s_idle got=done%b busy%b want=done0 busy0", tag, nn_done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if (busy !== 1'b0 || nn_done !== 1'b0 || layer_start !== 1'b0 || rd_bus.rd_req !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl got=busy%b done%b start%b req%b want=0000", busy, nn_done, layer_start, rd_bus.rd_req);
        end
        total++;
        if (layer_wt_addr !== '0 || layer_out_addr !== '0 || layer_cfg !== '0 || rd_bus.rd_addr !== '0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h/%h want=0", layer_wt_addr, layer_out_addr, layer_cfg, rd_bus.rd_addr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_three_layers();
        set_bases(WT, 8'd3);
        do_start();
        nn_wt_saddr = 32'hBAD0_0000;
        total++;
        if (busy !== 1'b1 || rd_bus.rd_req !== 1'b1) begin
            bad++; $display("FAIL start_latency got=busy%b req%b want=11", busy, rd_bus.rd_req);
        end
        do_layer(PARA, 32'h100, 32'h40, 32'hA0A0_0001, 32'hB0B0_0001, 8'd0, WT, BN, FIRST, MAP0, 0, 1'b0, 1'b0);
        pulse_done();
        do_layer(PARA + 32'h10, 32'h200, 32'h40, 32'hA0A0_0002, 32'hB0B0_0002, 8'd1,
                 WT + 32'h100, BN + 32'h40, MAP0, MAP1, 2, 1'b0, 1'b1);
        pulse_done();
        do_layer(PARA + 32'h20, 32'h80, 32'h40, 32'hA0A0_0003, 32'hB0B0_0003, 8'd2,
                 WT + 32'h300, BN + 32'h80, MAP1, MAP0, 0, 1'b0, 1'b0);
        pulse_done();
        check_finish("three");
        total++;
        if (layer_wt_addr !== WT + 32'h300 || layer_idx !== 8'd2) begin
            bad++; $display("FAIL out_hold got=%h/%0d want=%h/2", layer_wt_addr, layer_idx, WT + 32'h300);
        end
    endtask

    task automatic test_empty();
        set_bases(WT, 8'd0);
        do_start();
        total++;
        if (rd_bus.rd_req !== 1'b0) begin
            bad++; $display("FAIL empty_req got=%b want=0", rd_bus.rd_req);
        end
        check_finish("empty");
    endtask

    task automatic test_slow_ddr();
        set_bases(WT, 8'd1);
        do_start();
        do_layer(PARA, 32'h10, 32'h20, 32'h1234_5678, 32'h9ABC_DEF0, 8'd0, WT, BN, FIRST, MAP0, 5, 1'b1, 1'b0);
        pulse_done();
        check_finish("slow");
    endtask

    task automatic test_abort();
        set_bases(WT, 8'd3);
        do_start();
        do_layer(PARA, 32'h100, 32'h40, 32'h11, 32'h12, 8'd0, WT, BN, FIRST, MAP0, 0, 1'b0, 1'b0);
        pulse_done();
        do_layer(PARA + 32'h10, 32'h200, 32'h40, 32'h21, 32'h22, 8'd1,
                 WT + 32'h100, BN + 32'h40, MAP0, MAP1, 0, 1'b0, 1'b0);
        abort      = 1'b1;
        layer_done = 1'b1;
        tick();
        abort      = 1'b0;
        layer_done = 1'b0;
        total++;
        if (busy !== 1'b0 || rd_bus.rd_req !== 1'b0 || nn_done !== 1'b0) begin
            bad++; $display("FAIL abort_idle got=busy%b req%b done%b want=000", busy, rd_bus.rd_req, nn_done);
        end
        total++;
        if (layer_idx !== 8'd1 || layer_out_addr !== MAP1) begin
            bad++; $display("FAIL abort_hold got=%0d/%h want=1/%h", layer_idx, layer_out_addr, MAP1);
        end
        tick();
        total++;
        if (nn_done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_no_done got=done%b busy%b want=00", nn_done, busy);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL start_with_abort got=%b want=0", busy);
        end
        nn_layers_num = 8'd1;
        do_start();
        do_layer(PARA, 32'h300, 32'h50, 32'h31, 32'h32, 8'd0, WT, BN, FIRST, MAP0, 1, 1'b0, 1'b0);
        pulse_done();
        check_finish("rerun");
    endtask

    task automatic test_wrap();
        set_bases(32'hFFFF_FF00, 8'd2);
        do_start();
        do_layer(PARA, 32'h200, 32'h40, 32'h41, 32'h42, 8'd0, 32'hFFFF_FF00, BN, FIRST, MAP0, 0, 1'b0, 1'b0);
        pulse_done();
        do_layer(PARA + 32'h10, 32'h10, 32'h10, 32'h51, 32'h52, 8'd1,
                 32'h0000_0100, BN + 32'h40, MAP0, MAP1, 0, 1'b0, 1'b0);
        pulse_done();
        check_finish("wrap");
    endtask

    task automatic test_async_reset();
        set_bases(WT, 8'd2);
        do_start();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || rd_bus.rd_req !== 1'b0 || nn_done !== 1'b0) begin
            bad++; $display("FAIL async_reset got=busy%b req%b done%b want=000", busy, rd_bus.rd_req, nn_done);
        end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || layer_start !== 1'b0) begin
            bad++; $display("FAIL after_reset got=busy%b start%b want=00", busy, layer_start);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        start          = 1'b0;
        abort          = 1'b0;
        layer_done     = 1'b0;
        rd_bus.rd_ack  = 1'b0;
        rd_bus.rd_vld  = 1'b0;
        rd_bus.rd_data = '0;
        set_bases(WT, 8'd0);
        test_reset();
        test_three_layers();
        test_empty();
        test_slow_ddr();
        test_abort();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
